// File: rtl/sme_pkg.sv
// Shared types and constants for the SME host-side job issuer.
// Character width, buffer depths, FSM state encoding and result bundle.
package sme_pkg;

    localparam int CHAR_W  = 8;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    localparam logic [CHAR_W-1:0] WILDCARD = 8'h2E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_STR,
        ST_SEND_PAT,
        ST_WAIT,
        ST_RESULT
    } state_e;

    typedef struct packed {
        logic       match;
        logic [4:0] index;
        logic       err;
        logic       timeout;
    } result_t;

endpackage

// File: rtl/sme_char_buf.sv
// String and pattern character buffers for the SME job issuer.
// One write port and one combinational read port per register file.
module sme_char_buf
    import sme_pkg::*;
(
    input  logic              clk,
    input  logic              str_we,
    input  logic              pat_we,
    input  logic [4:0]        waddr,
    input  logic [CHAR_W-1:0] wdata,
    input  logic [4:0]        str_raddr,
    output logic [CHAR_W-1:0] str_rdata,
    input  logic [2:0]        pat_raddr,
    output logic [CHAR_W-1:0] pat_rdata
);

    logic [CHAR_W-1:0] str_q [STR_MAX];
    logic [CHAR_W-1:0] pat_q [PAT_MAX];

    // Contents are undefined after reset, so the arrays carry no reset.
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_q[waddr] <= wdata;
        end
        if (pat_we) begin
            pat_q[waddr[2:0]] <= wdata;
        end
    end

    assign str_rdata = str_q[str_raddr];
    assign pat_rdata = pat_q[pat_raddr];

endmodule

// File: rtl/sme_job_issuer.sv
// Host-side driver for the string-matching engine: serialises a buffered
// string/pattern, waits for the engine result and reports it as a pulse.
module sme_job_issuer
    import sme_pkg::*;
#(
    parameter int STR_MAX     = sme_pkg::STR_MAX,
    parameter int PAT_MAX     = sme_pkg::PAT_MAX,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [4:0]        wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_str_len,
    input  logic [3:0]        cmd_pat_len,
    input  logic              cmd_reuse_str,
    output logic [CHAR_W-1:0] sme_chardata,
    output logic              sme_isstring,
    output logic              sme_ispattern,
    input  logic              sme_valid,
    input  logic              sme_match,
    input  logic [4:0]        sme_match_index,
    output logic              res_valid,
    output logic              res_match,
    output logic [4:0]        res_index,
    output logic              res_err,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [5:0] STR_MAX_L = 6'(STR_MAX);
    localparam logic [3:0] PAT_MAX_L = 4'(PAT_MAX);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic [5:0]        str_len_q, str_len_d;
    logic [3:0]        pat_len_q, pat_len_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        timer_q, timer_d;
    logic              str_loaded_q, str_loaded_d;
    result_t           pend_q, pend_d;
    result_t           res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic [CHAR_W-1:0] chardata_q, chardata_d;
    logic              isstring_q, isstring_d;
    logic              ispattern_q, ispattern_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;

    logic [CHAR_W-1:0] str_rdata, pat_rdata;
    logic              wr_ok, cmd_bad, str_last, pat_last;

    // cmd_ready_q is high exactly while idle, so it doubles as the write gate.
    assign wr_ok = wr_en && cmd_ready_q;

    sme_char_buf u_buf (
        .clk       (clk),
        .str_we    (wr_ok && !wr_sel),
        .pat_we    (wr_ok && wr_sel),
        .waddr     (wr_addr),
        .wdata     (wr_data),
        .str_raddr (cnt_q),
        .str_rdata (str_rdata),
        .pat_raddr (cnt_q[2:0]),
        .pat_rdata (pat_rdata)
    );

    assign str_last = (cnt_q == 5'(str_len_q - 6'd1));
    assign pat_last = (cnt_q == {2'b00, 3'(pat_len_q - 4'd1)});

    assign cmd_bad = (cmd_pat_len == 4'd0) || (cmd_pat_len > PAT_MAX_L)
        || (cmd_reuse_str ? !str_loaded_q
                          : (cmd_str_len == 6'd0) || (cmd_str_len > STR_MAX_L));

    always_comb begin
        state_d      = state_q;
        str_len_d    = str_len_q;
        pat_len_d    = pat_len_q;
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        str_loaded_d = str_loaded_q;
        pend_d       = pend_q;
        res_d        = res_q;
        res_valid_d  = 1'b0;
        chardata_d   = '0;
        isstring_d   = 1'b0;
        ispattern_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    str_len_d = cmd_str_len;
                    pat_len_d = cmd_pat_len;
                    cnt_d     = '0;
                    if (cmd_bad) begin
                        pend_d  = '{match: 1'b0, index: 5'd0,
                                    err: 1'b1, timeout: 1'b0};
                        state_d = ST_RESULT;
                    end else if (cmd_reuse_str) begin
                        state_d = ST_SEND_PAT;
                    end else begin
                        state_d = ST_SEND_STR;
                    end
                end
            end
            ST_SEND_STR: begin
                chardata_d = str_rdata;
                isstring_d = 1'b1;
                cnt_d      = cnt_q + 5'd1;
                if (str_last) begin
                    cnt_d        = '0;
                    str_loaded_d = 1'b1;
                    state_d      = ST_SEND_PAT;
                end
            end
            ST_SEND_PAT: begin
                chardata_d  = pat_rdata;
                ispattern_d = 1'b1;
                cnt_d       = cnt_q + 5'd1;
                if (pat_last) begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sme_valid) begin
                    pend_d  = '{match: sme_match, index: sme_match_index,
                                err: 1'b0, timeout: 1'b0};
                    state_d = ST_RESULT;
                end else if (timer_q == TO_LAST) begin
                    // Engine state is unknown, so a kept string is no longer trusted.
                    pend_d       = '{match: 1'b0, index: 5'd0,
                                     err: 1'b0, timeout: 1'b1};
                    str_loaded_d = 1'b0;
                    state_d      = ST_RESULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_RESULT: begin
                res_valid_d = 1'b1;
                res_d       = pend_q;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            str_len_q    <= '0;
            pat_len_q    <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            str_loaded_q <= 1'b0;
            pend_q       <= '0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            chardata_q   <= '0;
            isstring_q   <= 1'b0;
            ispattern_q  <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            str_len_q    <= str_len_d;
            pat_len_q    <= pat_len_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            str_loaded_q <= str_loaded_d;
            pend_q       <= pend_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            chardata_q   <= chardata_d;
            isstring_q   <= isstring_d;
            ispattern_q  <= ispattern_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign sme_chardata  = chardata_q;
    assign sme_isstring  = isstring_q;
    assign sme_ispattern = ispattern_q;
    assign res_valid     = res_valid_q;
    assign res_match     = res_q.match;
    assign res_index     = res_q.index;
    assign res_err       = res_q.err;
    assign res_timeout   = res_q.timeout;

endmodule

// File: doc/sme_job_issuer.md
Name: sme_job_issuer

Overview:
- Host-side driver for the string-matching engine (SME) interface.
- Holds one string (≤32 chars) and one pattern (≤8 chars) in a local buffer, then serializes them onto chardata/isstring/ispattern.
- Waits for the engine's valid pulse, captures match/match_index and returns them as a one-cycle result with error/timeout status.
- Sits between the system controller and the SME instance, which is the receiving end of the same protocol.

Parameters:
- STR_MAX, 32, maximum string length in chars.
- PAT_MAX, 8, maximum pattern length in chars.
- TIMEOUT_CYC, 255, WAIT cycles before a job is abandoned; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  buffer write strobe; ignored while busy=1.
- wr_sel  in  1  0 = string buffer, 1 = pattern buffer.
- wr_addr  in  5  char index; pattern uses bits [2:0].
- wr_data  in  8  character.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high in IDLE only.
- cmd_str_len  in  6  string length, 1..32.
- cmd_pat_len  in  4  pattern length, 1..8.
- cmd_reuse_str  in  1  skip string send; engine keeps its previous string.
- sme_chardata  out  8  character to engine.
- sme_isstring  out  1  string char qualifier.
- sme_ispattern  out  1  pattern char qualifier.
- sme_valid  in  1  engine result strobe.
- sme_match  in  1  engine match flag.
- sme_match_index  in  5  engine match position.
- res_valid  out  1  one-cycle result pulse.
- res_match  out  1  captured match.
- res_index  out  5  captured index.
- res_err  out  1  rejected command.
- res_timeout  out  1  engine did not answer.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; str_loaded=0; counters 0; buffer contents undefined.
- All outputs are registered on posedge. They are therefore stable when the engine samples on negedge.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, RESULT.
- IDLE, on cmd_valid&&cmd_ready (edge T):
  - Latch lengths and the reuse flag.
  - Error check: str_len∉1..32 (when reuse=0), pat_len∉1..8, or reuse=1 with str_loaded=0.
  - Error → RESULT with res_err=1; no characters are driven.
  - reuse=0 → SEND_STR. reuse=1 → SEND_PAT.
- SEND_STR:
  - Drives str_buf[0..len-1] at edges T+1..T+len with sme_isstring=1, one char per cycle, back-to-back.
  - After the last char → SEND_PAT.
  - str_loaded is set when the last char is driven.
- SEND_PAT:
  - Starts on the cycle immediately after the last string char, or at T+1 when reuse=1.
  - Drives pat_buf[0..pat_len-1] with sme_ispattern=1.
  - isstring and ispattern are never high together.
  - After the last char → WAIT.
- WAIT:
  - chardata=0, both qualifiers 0, timer counts from 0.
  - sme_valid=1 → capture match/index → RESULT.
  - Timer reaches TIMEOUT_CYC → RESULT with res_timeout=1, res_match=0, res_index=0, and str_loaded cleared (engine state unknown).
  - If sme_valid and timeout occur in the same cycle, sme_valid wins.
- RESULT: res_valid=1 for exactly one cycle with the status fields → IDLE. This guarantees at least one idle cycle between jobs.
- Status fields hold their value until the next res_valid.
- sme_valid outside WAIT is ignored.
- Writes while busy are dropped. This protects buffer contents mid-send.
- Reset mid-job: immediate return to reset values, with qualifiers deasserted asynchronously; no res_valid is produced.
- Pattern chars are sent verbatim; wildcard 0x2E gets no special handling here.
- Latency, non-reuse job: result at T + str_len + pat_len + W + 2, where W = engine response cycles.

Decomposition:
- Package sme_pkg:
  - CHAR_W=8, STR_MAX=32, PAT_MAX=8, WILDCARD=8'h2E.
  - State enum for IDLE/SEND_STR/SEND_PAT/WAIT/RESULT.
  - Result struct {match, index, err, timeout}.
- One sub-module, sme_char_buf:
  - 32x8 string and 8x8 pattern register files.
  - One write port and one combinational read port per file.
- The FSM, counters and timer stay in sme_job_issuer.

Test Plan:
- Load "ABCDE", pattern "CD", str_len=5, pat_len=2 → isstring high for 5 cycles (0x41..0x45), ispattern high for 2 (0x43,0x44); behavioural engine answers match=1 index=2 → res_valid pulse with res_match=1, res_index=2, err=0, timeout=0.
- Follow-up job with reuse=1, pattern "E." → isstring is never asserted and ispattern goes high 1 cycle after acceptance; engine answers no match → res_match=0.
- cmd_pat_len=9, or reuse=1 immediately after reset → res_err=1 one cycle after acceptance and no qualifier activity on the engine interface.
- Engine never asserts valid with TIMEOUT_CYC=16 → res_timeout=1 after 16 WAIT cycles, then reuse=1 is rejected with res_err=1.
- Assert reset during SEND_STR at char 3 of 32 → qualifiers drop immediately and cmd_ready=1 after release; wr_en during busy leaves the buffer unchanged (read back via a repeat job).
- 32-char string with 8-char pattern, back-to-back jobs → exactly 32 then 8 qualifier cycles, no gap between them, and one idle cycle between jobs.
